ff_array_nr_nw: RTL and testbench
=================================

FF_ARRAY_NR_NW -- requirements
Module: ff_array_nr_nw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bits per entry.
REQ-002 SHALL have parameter DEPTH, default 16, power of two and at least 2: number of entries; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NUM_WR, default 3: write ports; lower index has higher priority.
REQ-004 SHALL have parameter NUM_RD, default 4: read ports.
REQ-005 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port wr_en_i, input, NUM_WR: per-port write enable.
REQ-008 SHALL have port wr_addr_i, input, NUM_WR x AW: per-port entry index.
REQ-009 SHALL have port wr_data_i, input, NUM_WR x DATA_WIDTH: per-port write data.
REQ-010 SHALL have port inv_en_i, input, 1: invalidate-entry request.
REQ-011 SHALL have port inv_addr_i, input, AW: entry to invalidate.
REQ-012 SHALL have port flush_i, input, 1: invalidate all entries.
REQ-013 SHALL have port rd_en_i, input, NUM_RD: per-port read enable.
REQ-014 SHALL have port rd_addr_i, input, NUM_RD x AW: per-port read index.
REQ-015 SHALL have port rd_data_o, output, NUM_RD x DATA_WIDTH: read data.
REQ-016 SHALL have port rd_valid_o, output, NUM_RD: valid bit of the addressed entry.
REQ-017 SHALL have port valid_count_o, output, $clog2(DEPTH+1): number of valid entries.
REQ-018 SHALL have port wr_conflict_o, output, 1: registered flag, two or more enabled write ports hit the same address in the previous cycle.

Function
REQ-019 SHALL store DEPTH entries of DATA_WIDTH data plus one valid bit each.
REQ-020 SHALL, per entry, write data from the lowest-index enabled write port whose address matches; higher-index matching ports are dropped.
REQ-021 SHALL set the valid bit of every written entry on the same edge.
REQ-022 SHALL clear the valid bit of inv_addr_i on the edge when inv_en_i=1, unless that entry is also written that cycle (write wins).
REQ-023 SHALL, on flush_i=1, clear all valid bits; entries written in the same cycle end valid (write wins over flush); data bits are never cleared by flush or invalidate.
REQ-024 SHALL drive rd_data_o[r] combinationally as entry data when rd_en_i[r]=1, else all zeros.
REQ-025 SHALL drive rd_valid_o[r] = rd_en_i[r] AND the addressed valid bit.
REQ-026 SHALL make written data visible to reads one cycle after the write edge (no same-cycle forwarding) unless REQ-033 applies.
REQ-027 SHALL update valid_count_o registered, equal to the popcount of valid bits after each edge; it never exceeds DEPTH or wraps below 0.
REQ-028 SHALL set wr_conflict_o for exactly one cycle after any cycle with an address collision among enabled write ports; it is 0 otherwise.
REQ-029 SHALL allow any number of read ports to address the same entry simultaneously.

Reset
REQ-030 SHALL, on posedge with rst=1, clear all data bits, all valid bits, valid_count_o and wr_conflict_o to 0; rst has priority over all writes, invalidates and flushes.
REQ-031 SHALL, during reset, present rd_data_o=0 and rd_valid_o=0 for every enabled read the cycle after reset is taken.
REQ-032 SHALL resume normal operation on the first edge with rst=0; an in-flight write in the reset cycle is discarded.

Configuration
REQ-033 SHALL, when macro FF_ARRAY_BYPASS_EN is defined, forward same-cycle write data to a matching enabled read (highest-priority matching write port) with rd_valid_o=1; without it, reads return pre-edge contents per REQ-026.

Verification
REQ-034 SHALL cover: reset, then read all entries on 4 ports -> rd_data_o=0, rd_valid_o=0, valid_count_o=0.
REQ-035 SHALL cover: ports 0,1,2 write addr 5 with 0xA, 0xB, 0xC same cycle -> next cycle entry 5 reads 0xA, valid_count_o=1, wr_conflict_o=1 for one cycle.
REQ-036 SHALL cover: fill all 16 entries, then inv_en_i addr 3 plus write addr 3 =0x33 same cycle -> entry 3 valid with 0x33, valid_count_o=16; next inv addr 3 alone -> valid_count_o=15, data still 0x33.
REQ-037 SHALL cover: flush_i with write addr 7 =0x77 same cycle, 16 valid entries -> valid_count_o=1, only entry 7 valid.
REQ-038 SHALL cover: write addr 2 =0x22 with read port 0 addr 2 same cycle -> rd_data_o[0]=0x22 with FF_ARRAY_BYPASS_EN, old value without; rd_en_i[0]=0 -> 0.
REQ-039 SHALL cover: rst asserted mid-stream while writing addr 9 -> entry 9 reads 0 and invalid after reset.

Source files
------------

// File: rtl/ff_array_nr_nw_if.sv
// ff_array_nr_nw_if: write/invalidate/flush/read bus of the flop array
interface ff_array_nr_nw_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_WR     = 3,
  parameter int NUM_RD     = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [NUM_WR-1:0]                 wr_en_i;
  logic [NUM_WR-1:0][AW-1:0]         wr_addr_i;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i;
  logic                              inv_en_i;
  logic [AW-1:0]                     inv_addr_i;
  logic                              flush_i;
  logic [NUM_RD-1:0]                 rd_en_i;
  logic [NUM_RD-1:0][AW-1:0]         rd_addr_i;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o;
  logic [NUM_RD-1:0]                 rd_valid_o;
  logic [CW-1:0]                     valid_count_o;
  logic                              wr_conflict_o;
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, inv_en_i, inv_addr_i, flush_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, valid_count_o, wr_conflict_o
  );
  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, inv_en_i, inv_addr_i, flush_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, valid_count_o, wr_conflict_o
  );
endinterface

// File: rtl/ff_array_nr_nw.sv
// ff_array_nr_nw: multi-port flop array with valid bits; FF_ARRAY_BYPASS_EN enables same-cycle write-to-read forwarding
module ff_array_nr_nw #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_WR     = 3,
  parameter int NUM_RD     = 4
) (
  input logic             clk,
  input logic             rst,
  ff_array_nr_nw_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]                 valid_q, valid_d, hit;
  logic [CW-1:0]                    count_q, count_d;
  logic                             conflict_q, conflict_d;
  // next state: lowest-index write port wins per entry; writes beat flush/invalidate
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    hit        = '0;
    count_d    = '0;
    conflict_d = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = NUM_WR - 1; p >= 0; p--)
        if (bus.wr_en_i[p] && bus.wr_addr_i[p] == AW'(e)) begin
          hit[e]    = 1'b1;
          data_d[e] = bus.wr_data_i[p];
        end
      valid_d[e] = hit[e] | (valid_q[e] & ~bus.flush_i & ~(bus.inv_en_i && bus.inv_addr_i == AW'(e)));
      count_d    = count_d + CW'(valid_d[e]);
    end
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (bus.wr_en_i[i] && bus.wr_en_i[j] && bus.wr_addr_i[i] == bus.wr_addr_i[j]) conflict_d = 1'b1;
  end
  // state register; reset clears data too so post-reset reads are zero
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
    end
  end
  // combinational read ports, zeroed when not enabled
  always_comb begin
    bus.rd_data_o  = '0;
    bus.rd_valid_o = '0;
    for (int r = 0; r < NUM_RD; r++)
      if (bus.rd_en_i[r]) begin
        bus.rd_data_o[r]  = data_q[bus.rd_addr_i[r]];
        bus.rd_valid_o[r] = valid_q[bus.rd_addr_i[r]];
`ifdef FF_ARRAY_BYPASS_EN
        for (int p = NUM_WR - 1; p >= 0; p--)
          if (bus.wr_en_i[p] && bus.wr_addr_i[p] == bus.rd_addr_i[r]) begin
            bus.rd_data_o[r]  = bus.wr_data_i[p];
            bus.rd_valid_o[r] = 1'b1;
          end
`endif
      end
  end
  assign bus.valid_count_o = count_q;
  assign bus.wr_conflict_o = conflict_q;
endmodule

// File: tb/tb_ff_array_nr_nw.sv
// tb_ff_array_nr_nw: directed scoreboard bench for ff_array_nr_nw
module tb_ff_array_nr_nw;
  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  chk_t q[$];
  ff_array_nr_nw_if #(.DATA_WIDTH(32), .DEPTH(16), .NUM_WR(3), .NUM_RD(4)) bus ();
  ff_array_nr_nw #(.DATA_WIDTH(32), .DEPTH(16), .NUM_WR(3), .NUM_RD(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] sel(int k, int i);
    return k == 0 ? bus.rd_data_o[i] : k == 1 ? 32'(bus.rd_valid_o[i]) :
           k == 2 ? 32'(bus.valid_count_o) : 32'(bus.wr_conflict_o);
  endfunction
  // monitor: compare every expectation scheduled for the current cycle
  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      automatic chk_t c = q.pop_front();
      automatic logic [31:0] act = sel(c.kind, c.idx);
      n_cmp++;
      if (c.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: missed at cycle %0d, required %0h", c.name, c.cyc, c.exp);
      end else if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h required %0h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    bus.wr_en_i  = '0;
    bus.inv_en_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.rd_en_i  = '0;
  endtask
  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en_i[p]   = 1'b1;
    bus.wr_addr_i[p] = 4'(a);
    bus.wr_data_i[p] = d;
  endtask
  task automatic rd(input int r, input int a);
    bus.rd_en_i[r]   = 1'b1;
    bus.rd_addr_i[r] = 4'(a);
  endtask
  task automatic expect_v(input int k, input int i, input logic [31:0] v, input string n);
    q.push_back('{cyc, k, i, v, n});
  endtask
  task automatic expect_rd(input int r, input logic [31:0] d, input logic v, input string n);
    expect_v(0, r, d, {n, "_data"});
    expect_v(1, r, 32'(v), {n, "_valid"});
  endtask
  initial begin
    rst            = 1'b1;
    bus.wr_en_i    = '0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.inv_en_i   = 1'b0;
    bus.inv_addr_i = '0;
    bus.flush_i    = 1'b0;
    bus.rd_en_i    = '0;
    bus.rd_addr_i  = '0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 4; r++) begin
        rd(r, 4 * k + r);
        expect_rd(r, 32'h0, 1'b0, "reset_rd");
      end
      expect_v(2, 0, 0, "reset_count");
      expect_v(3, 0, 0, "reset_conflict");
      step();
    end
    rst = 1'b0;
    wr(0, 5, 32'hA);
    wr(1, 5, 32'hB);
    wr(2, 5, 32'hC);
    step();
    rd(0, 5);
    expect_rd(0, 32'hA, 1'b1, "prio_addr5");
    expect_v(2, 0, 1, "count_after_collide");
    expect_v(3, 0, 1, "conflict_set");
    step();
    expect_v(3, 0, 0, "conflict_clear");
    wr(1, 4, 32'h41);
    wr(2, 4, 32'h42);
    step();
    rd(0, 4);
    expect_rd(0, 32'h41, 1'b1, "prio_p1_over_p2");
    expect_v(2, 0, 2, "count_two");
    expect_v(3, 0, 1, "conflict_p1p2");
    for (int e = 0; e < 16; e++) begin
      wr(0, e, 32'h1000 + e);
      step();
    end
    expect_v(2, 0, 16, "count_full");
    rd(1, 15);
    expect_rd(1, 32'h100F, 1'b1, "fill_e15");
    bus.inv_en_i   = 1'b1;
    bus.inv_addr_i = 4'd3;
    wr(1, 3, 32'h33);
    step();
    rd(0, 3);
    expect_rd(0, 32'h33, 1'b1, "inv_vs_write");
    expect_v(2, 0, 16, "count_write_wins");
    expect_v(3, 0, 0, "conflict_none");
    bus.inv_en_i   = 1'b1;
    bus.inv_addr_i = 4'd3;
    step();
    expect_v(2, 0, 15, "count_after_inv");
    rd(1, 3);
    expect_rd(1, 32'h33, 1'b0, "inv_keeps_data");
    wr(0, 3, 32'h3);
    step();
    expect_v(2, 0, 16, "count_refull");
    bus.flush_i = 1'b1;
    wr(2, 7, 32'h77);
    step();
    expect_v(2, 0, 1, "count_after_flush");
    rd(0, 7);
    rd(1, 0);
    rd(2, 15);
    rd(3, 3);
    expect_rd(0, 32'h77, 1'b1, "flush_e7");
    expect_rd(1, 32'h1000, 1'b0, "flush_e0");
    expect_rd(2, 32'h100F, 1'b0, "flush_e15");
    expect_rd(3, 32'h3, 1'b0, "flush_e3");
    step();
    wr(0, 2, 32'h22);
    rd(0, 2);
    rd(2, 2);
    bus.rd_addr_i[1] = 4'd2;
`ifdef FF_ARRAY_BYPASS_EN
    expect_rd(0, 32'h22, 1'b1, "bypass_p0");
    expect_rd(2, 32'h22, 1'b1, "bypass_p2");
`else
    expect_rd(0, 32'h1002, 1'b0, "nobypass_p0");
    expect_rd(2, 32'h1002, 1'b0, "nobypass_p2");
`endif
    expect_rd(1, 32'h0, 1'b0, "rd_disabled");
    step();
    for (int r = 0; r < 4; r++) begin
      rd(r, 2);
      expect_rd(r, 32'h22, 1'b1, "multi_rd_e2");
    end
    expect_v(2, 0, 2, "count_after_e2");
    expect_v(3, 0, 0, "conflict_single");
    rst = 1'b1;
    wr(0, 9, 32'h99);
    step();
    rst = 1'b0;
    rd(0, 9);
    rd(1, 2);
    expect_rd(0, 32'h0, 1'b0, "rst_drop_e9");
    expect_rd(1, 32'h0, 1'b0, "rst_clear_e2");
    expect_v(2, 0, 0, "count_after_rst");
    expect_v(3, 0, 0, "conflict_after_rst");
    wr(0, 9, 32'h9);
    step();
    rd(0, 9);
    expect_rd(0, 32'h9, 1'b1, "resume_e9");
    expect_v(2, 0, 1, "count_resume");
    step();
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks pending, required 0", q.size());
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
